// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, port indices and arbiter state type
//
// Purpose: common definitions for the virtual channel router blocks.
// Ports: none (package).
package router_pkg;

  localparam int NUM_PORTS = 5;

  localparam int PORT_CORE  = 0;
  localparam int PORT_LINK1 = 1;
  localparam int PORT_LINK2 = 2;
  localparam int PORT_LINK3 = 3;
  localparam int PORT_LINK4 = 4;

  // Downstream input-buffer depth in flits, also the reset credit count.
  localparam int DEFAULT_BUF_DEPTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - request/grant/credit bundle of one output port arbiter
//
// Purpose: groups the crossbar-side handshake of an output port arbiter.
// Signals:
//   req       sources -> arbiter, one bit per requesting source
//   flit_sent sources -> arbiter, owner moved one flit this cycle
//   credit_in sources -> arbiter, downstream freed one buffer slot
//   gnt       arbiter -> sources, registered one-hot grant
//   send_ok   arbiter -> sources, owner may send a flit
//   credits   arbiter -> sources, current credit count
//   busy      arbiter -> sources, arbiter holds a grant
//   err       arbiter -> sources, sticky protocol error
interface output_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0] req;
  logic               flit_sent;
  logic               credit_in;
  logic [NUM_REQ-1:0] gnt;
  logic               send_ok;
  logic [CNT_W-1:0]   credits;
  logic               busy;
  logic               err;

  modport master (
    output req, flit_sent, credit_in,
    input  gnt, send_ok, credits, busy, err
  );

  modport slave (
    input  req, flit_sent, credit_in,
    output gnt, send_ok, credits, busy, err
  );
endinterface

// File: rtl/output_port_arbiter_rr_pick.sv
// rtl/output_port_arbiter_rr_pick.sv - combinational circular priority picker
//
// Purpose: selects the first set request bit scanning upward from rr_ptr,
//          wrapping past the top bit back to bit 0.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  PTR_W    index with highest priority
//   sel    out NUM_REQ  one-hot selection, zero when no request
//   valid  out 1        at least one request present
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic               valid
);

  // One extra bit so rr_ptr + offset can exceed NUM_REQ-1 before wrapping.
  localparam int SW = PTR_W + 1;

  logic [SW-1:0] pos;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + SW'(i);
      if (pos >= SW'(NUM_REQ)) begin
        pos = pos - SW'(NUM_REQ);
      end
      if (!valid && req[pos[PTR_W-1:0]]) begin
        sel[pos[PTR_W-1:0]] = 1'b1;
        valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin packet-hold output port allocator with credit gating
//
// Purpose: grants one source ownership of this output for a whole packet,
//          rotating priority between packets, and gates flit transfer on a
//          downstream credit counter.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  output_port_arbiter_if.slave: req/flit_sent/credit_in in,
//        gnt/send_ok/credits/busy/err out
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  output_port_arbiter_if.slave     bus
);

  localparam int               PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(NUM_REQ - 1);

  arb_state_t         state;
  logic [NUM_REQ-1:0] gnt_q;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   rr_ptr;
  logic               busy_q;
  logic [CNT_W-1:0]   credits_q;
  logic               err_q;

  logic [NUM_REQ-1:0] pick_sel;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic               send_ok;
  logic               dec;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_sel[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // Only registered state feeds send_ok, so there is no input-to-output path.
  assign send_ok = (|gnt_q) && (credits_q != '0);
  assign dec     = bus.flit_sent & send_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_q  <= pick_sel;
            owner  <= pick_idx;
            busy_q <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          // Other requests are ignored until the owner finishes its packet.
          if (!bus.req[owner]) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            rr_ptr <= (owner == LAST_IX) ? '0 : owner + 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= FULL;
      err_q     <= 1'b0;
    end else begin
      case ({dec, bus.credit_in})
        2'b10: credits_q <= credits_q - 1'b1;
        2'b01: begin
          // A credit with the buffer already empty downstream is an overflow.
          if (credits_q == FULL) begin
            err_q <= 1'b1;
          end else begin
            credits_q <= credits_q + 1'b1;
          end
        end
        default: credits_q <= credits_q;
      endcase
      if (bus.flit_sent && !send_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.send_ok = send_ok;
  assign bus.credits = credits_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - directed self-checking bench for output_port_arbiter
module tb_output_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  output_port_arbiter_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

  output_port_arbiter #(
    .NUM_REQ   (4),
    .BUF_DEPTH (8),
    .CNT_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.flit_sent = 1'b0;
    bus.credit_in = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset state
    do_reset();
    step();
    check("rst_gnt", bus.gnt, 0);
    check("rst_credits", bus.credits, 8);
    check("rst_busy", bus.busy, 0);
    check("rst_send_ok", bus.send_ok, 0);
    check("rst_err", bus.err, 0);

    // Single request
    bus.req = 4'b0100;
    step();
    check("single_gnt", bus.gnt, 4);
    check("single_busy", bus.busy, 1);
    check("single_send_ok", bus.send_ok, 1);
    bus.req = 4'b0000;
    step();
    check("single_release_gnt", bus.gnt, 0);
    check("single_release_busy", bus.busy, 0);

    // Fairness: owners 0,1,2,3,0 with a one-cycle gap between grants
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      check($sformatf("fair_gnt%0d_a", k), bus.gnt, int'(exp_g));
      step();
      check($sformatf("fair_gnt%0d_b", k), bus.gnt, int'(exp_g));
      bus.req = 4'b1111 & ~exp_g;
      step();
      check($sformatf("fair_gap%0d", k), bus.gnt, 0);
      bus.req = 4'b1111;
      step();
    end
    bus.req = 4'b0000;
    step();
    step();

    // Credit exhaustion
    do_reset();
    bus.req = 4'b0001;
    step();
    check("exh_gnt", bus.gnt, 1);
    bus.flit_sent = 1'b1;
    for (int k = 0; k < 8; k++) step();
    check("exh_credits0", bus.credits, 0);
    check("exh_send_ok0", bus.send_ok, 0);
    check("exh_err_before", bus.err, 0);
    step();
    check("exh_err_9th", bus.err, 1);
    check("exh_credits_9th", bus.credits, 0);
    bus.flit_sent = 1'b0;
    bus.credit_in = 1'b1;
    step();
    bus.credit_in = 1'b0;
    check("exh_credits1", bus.credits, 1);
    check("exh_send_ok1", bus.send_ok, 1);

    // Simultaneous flit_sent and credit_in at credits=3
    bus.credit_in = 1'b1;
    step();
    step();
    bus.credit_in = 1'b0;
    check("sim_credits_pre", bus.credits, 3);
    bus.flit_sent = 1'b1;
    bus.credit_in = 1'b1;
    step();
    bus.flit_sent = 1'b0;
    bus.credit_in = 1'b0;
    check("sim_credits_hold", bus.credits, 3);

    // Overflow: credit_in at full credits
    do_reset();
    bus.req = 4'b0001;
    step();
    check("ovf_err_before", bus.err, 0);
    bus.credit_in = 1'b1;
    step();
    bus.credit_in = 1'b0;
    check("ovf_credits", bus.credits, 8);
    check("ovf_err", bus.err, 1);
    bus.req = 4'b0000;
    step();

    // Reset mid-grant with owner 2 and credits 5
    do_reset();
    bus.req = 4'b0100;
    step();
    check("mid_gnt", bus.gnt, 4);
    bus.flit_sent = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("mid_credits5", bus.credits, 5);
    rst           = 1'b1;
    bus.credit_in = 1'b1;
    step();
    check("mid_rst_gnt", bus.gnt, 0);
    check("mid_rst_credits", bus.credits, 8);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_busy", bus.busy, 0);
    rst           = 1'b0;
    bus.flit_sent = 1'b0;
    bus.credit_in = 1'b0;
    bus.req       = 4'b1010;
    step();
    check("mid_rrptr_gnt", bus.gnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
